// File: rtl/cam_axis_framer.sv
// cam_axis_framer: locks onto camera frames read from a first-word-fall-through
// FIFO, checks the line and frame geometry, and re-emits the pixels as an
// AXI4-Stream video stream (tuser = start of frame, tlast = end of line).
// Output stage is a two-entry skid buffer (output register plus skid register),
// so the FIFO pop never has a combinational path from i_tready.
// The FIFO pop is also held off in SYNC/RESYNC while the skid register is
// still draining the tail of the previous frame; a lock beat must never land
// on a full pipeline.
// Optional build macro: CAM_FRAMER_GRAY_EN. When defined, each forwarded pixel
// is converted to 8-bit luma as it is loaded into the skid buffer.
module cam_axis_framer #(
  parameter int ACTIVE_W = 640,
  parameter int ACTIVE_H = 480,
  parameter int CNT_W    = 16
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_enable,
  input  logic             i_clear,
  input  logic             i_fifo_valid,
  input  logic [33:0]      i_fifo_data,
  output logic             o_fifo_ready,
  output logic             o_tvalid,
  output logic [15:0]      o_tdata,
  output logic             o_tuser,
  output logic             o_tlast,
  input  logic             i_tready,
  output logic             o_locked,
  output logic [CNT_W-1:0] o_frame_cnt,
  output logic [CNT_W-1:0] o_drop_cnt,
  output logic             o_err_line,
  output logic             o_err_sof
);

  localparam int XW = (ACTIVE_W > 1) ? $clog2(ACTIVE_W) : 1;
  localparam int YW = (ACTIVE_H > 1) ? $clog2(ACTIVE_H) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(ACTIVE_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(ACTIVE_H - 1);

  typedef enum logic [1:0] {
    SYNC   = 2'd0,
    STREAM = 2'd1,
    RESYNC = 2'd2
  } state_t;

  // Pixel formatting applied at skid-buffer load.
  function automatic logic [15:0] pix_fmt(input logic [15:0] p);
`ifdef CAM_FRAMER_GRAY_EN
    logic [7:0]  r8, g8, b8;
    logic [15:0] sum;
    r8  = {p[15:11], p[15:13]};
    g8  = {p[10:5],  p[10:9]};
    b8  = {p[4:0],   p[4:2]};
    // 77+150+29 = 256, so the weighted sum of three 8-bit values fits 16 bits
    sum = (16'd77 * {8'h00, r8}) + (16'd150 * {8'h00, g8}) + (16'd29 * {8'h00, b8});
    return {8'h00, sum[15:8]};
`else
    return p;
`endif
  endfunction

  state_t           state_q, state_d;
  logic [XW-1:0]    x_q, x_d;
  logic [YW-1:0]    y_q, y_d;
  logic [CNT_W-1:0] frame_cnt_q, drop_cnt_q;
  logic             err_line_q, err_sof_q;
  logic             fifo_ready_q;

  logic             out_vld_q, out_vld_d;
  logic [15:0]      out_data_q, out_data_d;
  logic             out_user_q, out_user_d;
  logic             out_last_q, out_last_d;
  logic             skid_vld_q, skid_vld_d;
  logic [15:0]      skid_data_q, skid_data_d;
  logic             skid_user_q, skid_user_d;
  logic             skid_last_q, skid_last_d;

  logic             beat_acc, in_sof, in_eol;
  logic [15:0]      in_pix, new_data;
  logic             at_x_last, at_origin;
  logic             fwd, fwd_user, fwd_last, drop, err_line_ev, err_sof_ev, frame_ev;
  logic             out_pop;
  logic             unused_fifo_bits;

  assign beat_acc         = i_fifo_valid && fifo_ready_q;
  assign in_pix           = i_fifo_data[33:18];
  assign in_sof           = i_fifo_data[1];
  assign in_eol           = i_fifo_data[0];
  assign unused_fifo_bits = ^i_fifo_data[17:2];
  assign at_x_last        = (x_q == X_LAST);
  assign at_origin        = (x_q == '0) && (y_q == '0);
  assign new_data         = pix_fmt(in_pix);
  assign out_pop          = out_vld_q && i_tready;

  // Classify each accepted beat: forward, drop, or flag a geometry error.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    fwd         = 1'b0;
    fwd_user    = 1'b0;
    fwd_last    = 1'b0;
    drop        = 1'b0;
    err_line_ev = 1'b0;
    err_sof_ev  = 1'b0;
    frame_ev    = 1'b0;
    if (beat_acc) begin
      case (state_q)
        SYNC, RESYNC: begin
          if (in_sof && i_enable) begin
            // Lock beat becomes pixel (0,0); width >= 2 so it never ends a line
            fwd      = 1'b1;
            fwd_user = 1'b1;
            x_d      = XW'(1);
            y_d      = '0;
            state_d  = STREAM;
          end else begin
            drop = 1'b1;
            if (state_q == RESYNC && in_sof) state_d = SYNC;
          end
        end
        STREAM: begin
          if (in_sof && !at_origin) begin
            // Early SOF: abandon the partial frame and restart on this beat
            err_sof_ev = 1'b1;
            fwd        = 1'b1;
            fwd_user   = 1'b1;
            x_d        = XW'(1);
            y_d        = '0;
          end else if (in_eol != at_x_last) begin
            err_line_ev = 1'b1;
            drop        = 1'b1;
            x_d         = '0;
            y_d         = '0;
            state_d     = RESYNC;
          end else begin
            fwd      = 1'b1;
            fwd_user = at_origin;
            fwd_last = at_x_last;
            if (at_x_last) begin
              x_d = '0;
              if (y_q == Y_LAST) begin
                y_d      = '0;
                frame_ev = 1'b1;
                state_d  = SYNC;
              end else begin
                y_d = y_q + YW'(1);
              end
            end else begin
              x_d = x_q + XW'(1);
            end
          end
        end
        default: state_d = SYNC;
      endcase
    end
  end

  // Skid buffer steering: the skid register only fills when the output is stalled.
  always_comb begin
    out_vld_d   = out_vld_q;
    out_data_d  = out_data_q;
    out_user_d  = out_user_q;
    out_last_d  = out_last_q;
    skid_vld_d  = skid_vld_q;
    skid_data_d = skid_data_q;
    skid_user_d = skid_user_q;
    skid_last_d = skid_last_q;
    if (skid_vld_q) begin
      // The pop is off while the skid is full, so no new beat can arrive here
      if (out_pop) begin
        out_data_d = skid_data_q;
        out_user_d = skid_user_q;
        out_last_d = skid_last_q;
        skid_vld_d = 1'b0;
      end
    end else if (fwd) begin
      if (!out_vld_q || i_tready) begin
        out_vld_d  = 1'b1;
        out_data_d = new_data;
        out_user_d = fwd_user;
        out_last_d = fwd_last;
      end else begin
        skid_vld_d  = 1'b1;
        skid_data_d = new_data;
        skid_user_d = fwd_user;
        skid_last_d = fwd_last;
      end
    end else if (out_pop) begin
      out_vld_d = 1'b0;
    end
  end

  // Pipeline registers; FIFO pop is registered from the next skid occupancy.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      out_vld_q    <= 1'b0;
      out_data_q   <= '0;
      out_user_q   <= 1'b0;
      out_last_q   <= 1'b0;
      skid_vld_q   <= 1'b0;
      skid_data_q  <= '0;
      skid_user_q  <= 1'b0;
      skid_last_q  <= 1'b0;
      fifo_ready_q <= 1'b0;
    end else begin
      out_vld_q    <= out_vld_d;
      out_data_q   <= out_data_d;
      out_user_q   <= out_user_d;
      out_last_q   <= out_last_d;
      skid_vld_q   <= skid_vld_d;
      skid_data_q  <= skid_data_d;
      skid_user_q  <= skid_user_d;
      skid_last_q  <= skid_last_d;
      fifo_ready_q <= !skid_vld_d;
    end
  end

  // Frame-lock FSM, position counters and debug statistics (clear has priority).
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q     <= SYNC;
      x_q         <= '0;
      y_q         <= '0;
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
      err_line_q  <= 1'b0;
      err_sof_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      if (i_clear) begin
        frame_cnt_q <= '0;
        drop_cnt_q  <= '0;
        err_line_q  <= 1'b0;
        err_sof_q   <= 1'b0;
      end else begin
        if (frame_ev) frame_cnt_q <= frame_cnt_q + CNT_W'(1);
        if (drop && (drop_cnt_q != '1)) drop_cnt_q <= drop_cnt_q + CNT_W'(1);
        if (err_line_ev) err_line_q <= 1'b1;
        if (err_sof_ev) err_sof_q <= 1'b1;
      end
    end
  end

  assign o_fifo_ready = fifo_ready_q;
  assign o_tvalid     = out_vld_q;
  assign o_tdata      = out_data_q;
  assign o_tuser      = out_user_q;
  assign o_tlast      = out_last_q;
  assign o_locked     = (state_q == STREAM);
  assign o_frame_cnt  = frame_cnt_q;
  assign o_drop_cnt   = drop_cnt_q;
  assign o_err_line   = err_line_q;
  assign o_err_sof    = err_sof_q;

endmodule

// File: tb/tb_cam_axis_framer.sv
// Testbench for cam_axis_framer with a 4x2 frame geometry. A small FWFT FIFO
// model feeds a table of beats; forwarded output beats are collected and
// compared with the expected entries of the same table.
module tb_cam_axis_framer;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rstn, enable, clear;
  logic          fifo_valid, fifo_ready;
  logic [33:0]   fifo_data;
  logic          tvalid, tuser, tlast, tready;
  logic [15:0]   tdata;
  logic          locked, err_line, err_sof;
  logic [CW-1:0] frame_cnt, drop_cnt;

  cam_axis_framer #(.ACTIVE_W(W), .ACTIVE_H(H), .CNT_W(CW)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_enable(enable), .i_clear(clear),
    .i_fifo_valid(fifo_valid), .i_fifo_data(fifo_data), .o_fifo_ready(fifo_ready),
    .o_tvalid(tvalid), .o_tdata(tdata), .o_tuser(tuser), .o_tlast(tlast),
    .i_tready(tready), .o_locked(locked), .o_frame_cnt(frame_cnt),
    .o_drop_cnt(drop_cnt), .o_err_line(err_line), .o_err_sof(err_sof)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          seg;
    logic [15:0] pix;
    logic        sof, eol;
    logic        fwd, user, last;
  } vec_t;

  vec_t        vec[$];
  logic [33:0] fq[$];
  logic [17:0] outq[$];
  logic [17:0] expq[$];
  int          nchk = 0, nfail = 0, cyc = 0, mode = 0;
  logic        last_acc = 1'b0, held = 1'b0;
  logic [18:0] held_val = '0;

  function automatic logic [15:0] pal(input int i);
    case (i)
      0:       return 16'hFFFF;
      1:       return 16'hF800;
      2:       return 16'h07E0;
      default: return 16'h001F;
    endcase
  endfunction

  function automatic logic [15:0] exp_pix(input logic [15:0] p);
`ifdef CAM_FRAMER_GRAY_EN
    case (p)
      16'hFFFF: return 16'h00FF;
      16'hF800: return 16'h004C;
      16'h07E0: return 16'h0095;
      16'h001F: return 16'h001C;
      default:  return 16'h0000;
    endcase
`else
    return p;
`endif
  endfunction

  function automatic void add(input int seg, input logic [15:0] pix, input logic sof,
                              input logic eol, input logic fwd, input logic user,
                              input logic last);
    vec_t v;
    v.seg = seg; v.pix = pix; v.sof = sof; v.eol = eol;
    v.fwd = fwd; v.user = user; v.last = last;
    vec.push_back(v);
  endfunction

  function automatic void add_frame(input int seg, input logic fwd);
    for (int i = 0; i < W * H; i++)
      add(seg, pal(i % 4), i == 0, (i % W) == W - 1, fwd, fwd && (i == 0),
          fwd && ((i % W) == W - 1));
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One clock: FIFO model pop/drive, tready pattern, output capture, stall hold check.
  task automatic tick();
    logic [33:0] tmp;
    @(negedge clk);
    cyc++;
    if (last_acc) tmp = fq.pop_front();
    fifo_valid = (fq.size() > 0);
    fifo_data  = fifo_valid ? fq[0] : '0;
    case (mode)
      0:       tready = 1'b1;
      1:       tready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      default: tready = 1'b0;
    endcase
    if (held) chk("stall_hold", {13'd0, tvalid, tdata, tuser, tlast}, {13'd0, held_val});
    if (tvalid && tready) outq.push_back({tdata, tuser, tlast});
    held     = rstn && tvalid && !tready;
    held_val = {1'b1, tdata, tuser, tlast};
    last_acc = rstn && fifo_valid && fifo_ready;
  endtask

  task automatic push_seg(input int k);
    foreach (vec[i]) begin
      if (vec[i].seg == k) begin
        fq.push_back({vec[i].pix, 16'h0000, vec[i].sof, vec[i].eol});
        if (vec[i].fwd) expq.push_back({exp_pix(vec[i].pix), vec[i].user, vec[i].last});
      end
    end
  endtask

  task automatic drain();
    int k = 0;
    while ((fq.size() > 0 || tvalid || last_acc) && k < 400) begin
      tick();
      k++;
    end
    if (k >= 400) begin
      nchk++;
      nfail++;
      $display("FAIL drain_timeout: fifo_left %0d, required 0", fq.size());
    end
    tick();
    tick();
  endtask

  task automatic run_seg(input int k);
    push_seg(k);
    drain();
    chk($sformatf("seg%0d_beats", k), outq.size(), expq.size());
    for (int i = 0; i < expq.size() && i < outq.size(); i++)
      chk($sformatf("seg%0d_beat%0d", k, i), {14'd0, outq[i]}, {14'd0, expq[i]});
    outq.delete();
    expq.delete();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tick();
    chk("clear_frame_cnt", frame_cnt, 0);
    chk("clear_drop_cnt", drop_cnt, 0);
    chk("clear_err_line", err_line, 0);
    chk("clear_err_sof", err_sof, 0);
  endtask

  task automatic chk_status(input string nm, input int fc, input int dc,
                            input logic el, input logic es, input logic lk);
    chk({nm, "_frame_cnt"}, frame_cnt, fc);
    chk({nm, "_drop_cnt"}, drop_cnt, dc);
    chk({nm, "_err_line"}, err_line, el);
    chk({nm, "_err_sof"}, err_sof, es);
    chk({nm, "_locked"}, locked, lk);
  endtask

  initial begin
    // Seg 1: three junk beats, then a clean frame
    for (int i = 0; i < 3; i++) add(1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    add_frame(1, 1'b1);
    // Seg 2: same frame, replayed under backpressure
    add_frame(2, 1'b1);
    // Seg 3: eol on x=2 of line 0; seg 4: junk then a clean frame
    add(3, pal(0), 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    add(3, pal(1), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    add(3, pal(2), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    add(4, pal(3), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    add(4, pal(0), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    add_frame(4, 1'b1);
    // Seg 5/6: sof at (1,1) restarts the frame, which then completes
    for (int i = 0; i < 13; i++) begin
      logic s, e, u;
      s = (i == 0) || (i == 5);
      e = (i == 3) || (i == 8) || (i == 12);
      u = s;
      add((i < 9) ? 5 : 6, pal(i % 4), s, e, 1'b1, u, e);
    end
    // Seg 7: enable low, everything dropped; seg 8: enable high, locks
    add_frame(7, 1'b0);
    add_frame(8, 1'b1);
    // Seg 9: frame carrying full-white and full-red first pixels
    add_frame(9, 1'b1);
    // Seg 10: frame interrupted by reset; seg 11: clean frame afterwards
    add_frame(10, 1'b0);
    add_frame(11, 1'b1);

    rstn = 1'b0; enable = 1'b1; clear = 1'b0; tready = 1'b1;
    fifo_valid = 1'b0; fifo_data = '0;
    repeat (3) tick();
    chk("rst_tvalid", tvalid, 0);
    chk("rst_tdata", tdata, 0);
    chk("rst_fifo_ready", fifo_ready, 0);
    chk_status("rst", 0, 0, 1'b0, 1'b0, 1'b0);
    rstn = 1'b1;
    tick();
    chk("idle_fifo_ready", fifo_ready, 1);

    run_seg(1);
    chk_status("clean", 1, 3, 1'b0, 1'b0, 1'b0);

    do_clear();
    mode = 1;
    run_seg(2);
    mode = 0;
    chk_status("bp", 1, 0, 1'b0, 1'b0, 1'b0);

    do_clear();
    run_seg(3);
    chk_status("eol_err", 0, 1, 1'b1, 1'b0, 1'b0);
    run_seg(4);
    chk_status("resync", 1, 3, 1'b1, 1'b0, 1'b0);

    do_clear();
    run_seg(5);
    chk_status("sof_err", 0, 0, 1'b0, 1'b1, 1'b1);
    run_seg(6);
    chk_status("sof_done", 1, 0, 1'b0, 1'b1, 1'b0);

    do_clear();
    enable = 1'b0;
    run_seg(7);
    chk_status("disabled", 0, 8, 1'b0, 1'b0, 1'b0);
    enable = 1'b1;
    run_seg(8);
    chk_status("enabled", 1, 8, 1'b0, 1'b0, 1'b0);

    run_seg(9);
    chk_status("pix", 2, 8, 1'b0, 1'b0, 1'b0);

    mode = 2;
    push_seg(10);
    repeat (6) tick();
    chk("stalled_tvalid", tvalid, 1);
    chk("stalled_fifo_ready", fifo_ready, 0);
    chk("stalled_locked", locked, 1);
    rstn = 1'b0;
    held = 1'b0;
    tick();
    chk("midrst_tvalid", tvalid, 0);
    chk("midrst_tdata", tdata, 0);
    chk("midrst_fifo_ready", fifo_ready, 0);
    chk_status("midrst", 0, 0, 1'b0, 1'b0, 1'b0);
    rstn = 1'b1;
    mode = 0;
    outq.delete();
    expq.delete();
    run_seg(11);
    chk_status("after_rst", 1, 6, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", nchk, nfail);
    $finish;
  end

endmodule
